// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter that shares one synchronous-read ROM among NUM_REQ requesters.
// It accepts one read per cycle and routes the returned word to its owner through a tag pipeline.
module rom_rr_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int DEPTH       = 16,
  parameter  int ROM_LATENCY = 1,
  localparam int ADDR_WIDTH  = $clog2(DEPTH),
  localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_resp_valid,
  output logic [DATA_WIDTH-1:0]         o_resp_data,
  output logic [ADDR_WIDTH-1:0]         o_rom_rd_addr,
  input  logic [DATA_WIDTH-1:0]         i_rom_rd_data
);

  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   w_winner;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
  logic [ROM_LATENCY:0]  r_tag_vld;
  logic [ID_WIDTH-1:0]   r_tag_id [ROM_LATENCY+1];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign w_addr[g] = i_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // First valid requester at or after the pointer, wrapping; grant is held off during reset.
  always_comb begin
    w_winner = '0;
    w_hs     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hs && i_req_valid[ID_WIDTH'((int'(r_ptr) + k) % NUM_REQ)]) begin
        w_hs     = 1'b1;
        w_winner = ID_WIDTH'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    if (!rst_n) w_hs = 1'b0;
  end

  always_comb begin
    o_req_ready = '0;
    if (w_hs) o_req_ready[w_winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      o_rom_rd_addr <= '0;
      r_tag_vld     <= '0;
      for (int s = 0; s <= ROM_LATENCY; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_vld[0] <= w_hs;
      if (w_hs) begin
        o_rom_rd_addr <= w_addr[w_winner];
        r_tag_id[0]   <= w_winner;
        r_ptr         <= (int'(w_winner) == NUM_REQ-1) ? '0 : w_winner + 1'b1;
      end
      // Tag rides alongside the ROM's internal latency.
      for (int s = 1; s <= ROM_LATENCY; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  always_comb begin
    o_resp_valid = '0;
    if (r_tag_vld[ROM_LATENCY]) o_resp_valid[r_tag_id[ROM_LATENCY]] = 1'b1;
  end

  assign o_resp_data = i_rom_rd_data;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter with a 16-word synchronous ROM holding word[i]=i.
module tb_rom_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [7:0]  resp_data;
  logic [3:0]  rom_rd_addr;
  logic [7:0]  rom_rd_data;
  logic [7:0]  rom_mem [16];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) rom_mem[i] = 8'(i);
  always_ff @(posedge clk) rom_rd_data <= rom_mem[rom_rd_addr];

  rom_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_addr(req_addr),
    .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
    .o_rom_rd_addr(rom_rd_addr), .i_rom_rd_data(rom_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all requests held
    req_valid = 4'b1111;
    req_addr  = {4'h7, 4'h6, 4'h5, 4'h4};
    repeat (3) cyc();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp", 32'(resp_valid), 32'h0);
    chk("rst_romaddr", 32'(rom_rd_addr), 32'h0);
    rst_n = 1'b1;

    // Full rotation 0,1,2,3,0 then responses two cycles later
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      if (k == 5) req_valid = 4'b0000;
      #1;
      chk($sformatf("rot_ready_%0d", k), 32'(req_ready), (k < 5) ? (32'h1 << (k % 4)) : 32'h0);
      chk($sformatf("rot_resp_%0d", k), 32'(resp_valid),
          (k >= 2 && k <= 6) ? (32'h1 << ((k - 2) % 4)) : 32'h0);
      if (k >= 2 && k <= 6)
        chk($sformatf("rot_data_%0d", k), 32'(resp_data), 32'(4 + ((k - 2) % 4)));
    end

    // Single request from requester 2, address A (ptr=1)
    cyc();
    req_valid = 4'b0100;
    req_addr  = {4'h7, 4'hA, 4'h5, 4'h4};
    #1;
    chk("r2_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = 4'b0000;
    #1;
    chk("r2_resp_t1", 32'(resp_valid), 32'h0);
    cyc();
    chk("r2_resp_t2", 32'(resp_valid), 32'h4);
    chk("r2_data", 32'(resp_data), 32'h0A);
    cyc();
    chk("r2_resp_t3", 32'(resp_valid), 32'h0);

    // Requester 3 streams addresses 0..15 back to back
    for (int j = 0; j < 18; j++) begin
      cyc();
      if (j < 16) begin
        req_valid = 4'b1000;
        req_addr[15:12] = j[3:0];
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (j < 16) chk($sformatf("s3_ready_%0d", j), 32'(req_ready), 32'h8);
      if (j >= 2) begin
        chk($sformatf("s3_resp_%0d", j), 32'(resp_valid), 32'h8);
        chk($sformatf("s3_data_%0d", j), 32'(resp_data), 32'(j - 2));
      end
      if (j >= 16) chk($sformatf("s3_romaddr_%0d", j), 32'(rom_rd_addr), 32'hF);
    end
    cyc();
    chk("s3_resp_end", 32'(resp_valid), 32'h0);

    // Pointer steering: req1 alone sets ptr=2, then req1+req3 contend
    req_addr = {4'h7, 4'h6, 4'h5, 4'h4};
    req_valid = 4'b0010;
    #1;
    chk("p_ready_a", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 4'b1010;
    #1;
    chk("p_ready_b", 32'(req_ready), 32'h8);
    cyc();
    chk("p_ready_c", 32'(req_ready), 32'h2);
    chk("p_resp_c", 32'(resp_valid), 32'h2);
    chk("p_data_c", 32'(resp_data), 32'h5);
    cyc();
    chk("p_ready_d", 32'(req_ready), 32'h8);
    chk("p_resp_d", 32'(resp_valid), 32'h8);
    chk("p_data_d", 32'(resp_data), 32'h7);
    cyc();
    req_valid = 4'b0000;
    #1;
    chk("p_resp_e", 32'(resp_valid), 32'h2);
    chk("p_data_e", 32'(resp_data), 32'h5);
    cyc();
    chk("p_resp_f", 32'(resp_valid), 32'h8);
    cyc();
    chk("p_resp_g", 32'(resp_valid), 32'h0);

    // Reset mid-flight discards the outstanding grant
    cyc();
    req_valid = 4'b0001;
    #1;
    chk("mr_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("mr_resp_in_rst", 32'(resp_valid), 32'h0);
    chk("mr_romaddr_in_rst", 32'(rom_rd_addr), 32'h0);
    cyc();
    chk("mr_resp_t2", 32'(resp_valid), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("mr_resp_t3", 32'(resp_valid), 32'h0);

    // Post-reset traffic: ptr back at 0, requester 2 wins, address A
    req_valid = 4'b0100;
    req_addr  = {4'h7, 4'hA, 4'h5, 4'h4};
    #1;
    chk("post_ready", 32'(req_ready), 32'h4);
    cyc();
    req_valid = 4'b0000;
    #1;
    chk("post_resp_t1", 32'(resp_valid), 32'h0);
    cyc();
    chk("post_resp_t2", 32'(resp_valid), 32'h4);
    chk("post_data", 32'(resp_data), 32'h0A);
    cyc();
    chk("post_resp_t3", 32'(resp_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
